toll_out_ctrl: RTL and testbench
================================

// Module: toll_out_ctrl
// PURPOSE
//  Output side of the toll-gate datapath: takes synchronised verdicts from the main toll FSM and drives
//  the external actuators (gate barrier, buzzer, fee display) with timed sequences. Sits between the
//  controller FSM and the board pins, mirroring the input synchroniser on the receive side.
// PARAMETERS
//  GATE_TMO   200  max cycles gate stays open waiting for car_clear before forced close
//  CLOSE_CYC  20   cycles between close decision and return to IDLE (barrier travel time)
//  BUZZ_CYC   50   cycles buzzer sequence lasts after a rejected card
//  BLINK_CYC  5    half-period of buzzer blink (only with TOLL_BUZZ_BLINK_EN)
//  FEE_W      8    fee width in bits
// PORTS
//  clk        in   1      system clock
//  rst        in   1      reset, asynchronous, active-low
//  pass_ok    in   1      1-cycle pulse: card/payment accepted
//  pass_fail  in   1      1-cycle pulse: card rejected
//  fee        in   FEE_W  amount charged, sampled with pass_ok
//  car_clear  in   1      level, synchronised: vehicle has left gate zone
//  abort      in   1      1-cycle pulse: operator force-close
//  gate_open  out  1      barrier open drive
//  buzzer     out  1      buzzer drive
//  fee_disp   out  FEE_W  displayed fee
//  disp_valid out  1      fee_disp valid
//  busy       out  1      high in every state except IDLE
//  done       out  1      1-cycle pulse on return to IDLE
// BEHAVIOUR
//  - Reset (rst=0): state IDLE, timer 0, all outputs 0, immediately (async), incl. mid-sequence.
//  - States: IDLE, OPEN, CLOSE, ALARM. Registered outputs; decisions visible cycle after the input pulse.
//  - IDLE: pass_fail -> ALARM; else pass_ok -> OPEN, latch fee into fee_disp, disp_valid=1.
//    pass_ok and pass_fail same cycle: pass_fail wins, fee not latched.
//  - OPEN: gate_open=1, timer counts up from 0. car_clear=1 or timer==GATE_TMO-1 or abort -> CLOSE.
//  - CLOSE: gate_open=0, disp_valid stays 1, count CLOSE_CYC cycles -> IDLE, done=1 for 1 cycle,
//    disp_valid=0, fee_disp held (not cleared).
//  - ALARM: buzzer=1 for BUZZ_CYC cycles -> IDLE with done pulse. gate_open stays 0. abort -> IDLE at once.
//  - pass_ok/pass_fail outside IDLE: ignored, no queuing. abort in IDLE/CLOSE: ignored.
//  - Timer: single counter, width $clog2(max(GATE_TMO,CLOSE_CYC,BUZZ_CYC))+1, cleared on every state
//    change, never wraps (saturates at terminal count).
//  - busy = (state != IDLE); done and busy never both high in same cycle.
// CONFIGURATION
//  TOLL_BUZZ_BLINK_EN defined: in ALARM buzzer toggles every BLINK_CYC cycles, starting at 1,
//    forced 0 on ALARM exit. Not defined: buzzer steady 1 throughout ALARM. Other behaviour identical.
// STRUCTURE
//  - Shared package toll_pkg: state encoding (IDLE=2'b00, OPEN=2'b01, CLOSE=2'b10, ALARM=2'b11),
//    default timing constants, FEE_W.
//  - Sub-module toll_timer: clearable saturating up-counter with terminal-count compare
//    (inputs clr, limit; output tc). One instance; FSM and output regs live in toll_out_ctrl.
// TESTING (GATE_TMO=10, CLOSE_CYC=3, BUZZ_CYC=4, BLINK_CYC=1)
//  1. pass_ok, fee=8'h2A; car_clear at cycle 4 -> gate_open 1 next cycle, fee_disp=2A,
//     CLOSE 3 cycles, done pulse, busy low.
//  2. pass_ok, car_clear never -> gate_open high exactly 10 cycles then CLOSE, done after 3 more.
//  3. pass_ok+pass_fail same cycle -> ALARM, buzzer 4 cycles (blink 1,0,1,0 with macro), gate_open 0,
//     fee_disp unchanged.
//  4. pass_ok in OPEN with fee=8'h55 -> ignored, fee_disp stays 2A; abort in OPEN -> CLOSE next cycle.
//  5. rst low mid-OPEN -> gate_open, buzzer, disp_valid, busy 0 without clock edge; release -> IDLE,
//     accepts pass_ok.
//  6. abort in ALARM -> IDLE next cycle with done pulse, buzzer 0.

Source files
------------

// File: rtl/toll_pkg.sv
// Shared types and default timing for the toll-gate output controller.
package toll_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OPEN  = 2'b01,
    CLOSE = 2'b10,
    ALARM = 2'b11
  } toll_state_e;

  localparam int DEF_GATE_TMO  = 200;
  localparam int DEF_CLOSE_CYC = 20;
  localparam int DEF_BUZZ_CYC  = 50;
  localparam int DEF_BLINK_CYC = 5;
  localparam int TOLL_FEE_W    = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/toll_timer.sv
// Clearable saturating up-counter; tc flags count == limit and the count holds there.
module toll_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [TW-1:0] limit,
  output logic          tc
);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             cnt <= '0;
    else if (clr)         cnt <= '0;
    else if (cnt < limit) cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == limit);

endmodule

// File: rtl/toll_out_ctrl.sv
// Toll-gate actuator sequencer: barrier, buzzer and fee display driven from verdict pulses.
// Optional TOLL_BUZZ_BLINK_EN makes the buzzer blink with half-period BLINK_CYC while in ALARM.
module toll_out_ctrl
  import toll_pkg::*;
#(
  parameter int GATE_TMO  = DEF_GATE_TMO,
  parameter int CLOSE_CYC = DEF_CLOSE_CYC,
  parameter int BUZZ_CYC  = DEF_BUZZ_CYC,
  parameter int BLINK_CYC = DEF_BLINK_CYC,
  parameter int FEE_W     = TOLL_FEE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pass_ok,
  input  logic             pass_fail,
  input  logic [FEE_W-1:0] fee,
  input  logic             car_clear,
  input  logic             abort,
  output logic             gate_open,
  output logic             buzzer,
  output logic [FEE_W-1:0] fee_disp,
  output logic             disp_valid,
  output logic             busy,
  output logic             done
);

  localparam int TW = $clog2(max3(GATE_TMO, CLOSE_CYC, BUZZ_CYC)) + 1;

  if (GATE_TMO < 1 || CLOSE_CYC < 1 || BUZZ_CYC < 1 || BLINK_CYC < 1) begin : g_bad_param
    $error("toll_out_ctrl: timing parameters must be >= 1");
  end

  toll_state_e   state, nxt;
  logic [TW-1:0] limit;
  logic          tc;
  logic          clr;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (pass_fail) nxt = ALARM;
               else if (pass_ok) nxt = OPEN;
      OPEN:    if (car_clear || abort || tc) nxt = CLOSE;
      CLOSE:   if (tc) nxt = IDLE;
      ALARM:   if (abort || tc) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Terminal count is one below the duration so each state lasts exactly N cycles.
  always_comb begin
    limit = '0;
    unique case (state)
      OPEN:    limit = TW'(GATE_TMO - 1);
      CLOSE:   limit = TW'(CLOSE_CYC - 1);
      ALARM:   limit = TW'(BUZZ_CYC - 1);
      default: limit = '0;
    endcase
  end

  assign clr = (nxt != state);

  toll_timer #(.TW(TW)) u_tmr (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .limit (limit),
    .tc    (tc)
  );

`ifdef TOLL_BUZZ_BLINK_EN
  localparam int BW = $clog2(BLINK_CYC) + 1;
  logic [BW-1:0] blk_cnt;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      gate_open  <= 1'b0;
      buzzer     <= 1'b0;
      fee_disp   <= '0;
      disp_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef TOLL_BUZZ_BLINK_EN
      blk_cnt    <= '0;
`endif
    end else begin
      state      <= nxt;
      gate_open  <= (nxt == OPEN);
      disp_valid <= (nxt == OPEN) || (nxt == CLOSE);
      busy       <= (nxt != IDLE);
      done       <= (state != IDLE) && (nxt == IDLE);
      if (state == IDLE && nxt == OPEN) fee_disp <= fee;
`ifdef TOLL_BUZZ_BLINK_EN
      if (nxt != ALARM) begin
        buzzer  <= 1'b0;
        blk_cnt <= '0;
      end else if (state != ALARM) begin
        buzzer  <= 1'b1;
        blk_cnt <= '0;
      end else if (blk_cnt == BW'(BLINK_CYC - 1)) begin
        buzzer  <= ~buzzer;
        blk_cnt <= '0;
      end else begin
        blk_cnt <= blk_cnt + 1'b1;
      end
`else
      buzzer     <= (nxt == ALARM);
`endif
    end
  end

endmodule

// File: tb/tb_toll_out_ctrl.sv
// Vector-table bench for toll_out_ctrl with an expected-output queue; honours TOLL_BUZZ_BLINK_EN.
module tb_toll_out_ctrl;

  typedef struct packed {
    logic       po;
    logic       pf;
    logic [7:0] fee;
    logic       cc;
    logic       ab;
  } in_t;

  typedef struct packed {
    logic       go;
    logic       bz;
    logic [7:0] fd;
    logic       dv;
    logic       bs;
    logic       dn;
  } out_t;

  typedef struct {
    in_t   i;
    out_t  o;
    string name;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pass_ok = 1'b0, pass_fail = 1'b0, car_clear = 1'b0, abort = 1'b0;
  logic [7:0] fee = 8'h00;
  logic       gate_open, buzzer, disp_valid, busy, done;
  logic [7:0] fee_disp;

  int n_cmp = 0;
  int n_err = 0;

  vec_t  vec_q[$];
  out_t  exp_q[$];
  string nm_q[$];

  always #5 clk = ~clk;

  toll_out_ctrl #(
    .GATE_TMO(10), .CLOSE_CYC(3), .BUZZ_CYC(4), .BLINK_CYC(1), .FEE_W(8)
  ) dut (
    .clk(clk), .rst(rst), .pass_ok(pass_ok), .pass_fail(pass_fail), .fee(fee),
    .car_clear(car_clear), .abort(abort), .gate_open(gate_open), .buzzer(buzzer),
    .fee_disp(fee_disp), .disp_valid(disp_valid), .busy(busy), .done(done)
  );

  // Expected buzzer level in the k-th ALARM cycle.
  function automatic int bz(input int k);
`ifdef TOLL_BUZZ_BLINK_EN
    return (k % 2 == 0) ? 1 : 0;
`else
    return (k >= 0) ? 1 : 0;
`endif
  endfunction

  function automatic void add(input string nm, input int po, input int pf, input int fe,
                              input int cc, input int ab, input int go, input int b,
                              input int fd, input int dv, input int bs, input int dn);
    vec_t v;
    v.name = nm;
    v.i = '{po: 1'(po), pf: 1'(pf), fee: 8'(fe), cc: 1'(cc), ab: 1'(ab)};
    v.o = '{go: 1'(go), bz: 1'(b), fd: 8'(fd), dv: 1'(dv), bs: 1'(bs), dn: 1'(dn)};
    vec_q.push_back(v);
  endfunction

  task automatic chk(input string nm, input out_t exp);
    out_t act;
    act = '{go: gate_open, bz: buzzer, fd: fee_disp, dv: disp_valid, bs: busy, dn: done};
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got {go,bz,fd,dv,busy,done}=%b,%b,%h,%b,%b,%b expected %b,%b,%h,%b,%b,%b",
               nm, act.go, act.bz, act.fd, act.dv, act.bs, act.dn,
               exp.go, exp.bz, exp.fd, exp.dv, exp.bs, exp.dn);
    end
    n_cmp++;
    if (done === 1'b1 && busy === 1'b1) begin
      n_err++;
      $display("FAIL %s_done_busy: got done=1 busy=1 expected not both high", nm);
    end
  endtask

  task automatic drive(input in_t i);
    pass_ok   = i.po;
    pass_fail = i.pf;
    fee       = i.fee;
    car_clear = i.cc;
    abort     = i.ab;
  endtask

  // Called at a negedge: drive each vector, expect its outputs after the next posedge.
  task automatic run_vecs();
    vec_t v;
    while (vec_q.size() > 0) begin
      v = vec_q.pop_front();
      drive(v.i);
      exp_q.push_back(v.o);
      nm_q.push_back(v.name);
      @(posedge clk);
      @(negedge clk);
      chk(nm_q.pop_front(), exp_q.pop_front());
    end
    drive('0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_state", '0);
    rst = 1'b1;

    add("idle0",      0,0,8'h00,0,0, 0,0,8'h00,0,0,0);
    // 1: accepted card, car clears after a few cycles
    add("t1_open",    1,0,8'h2A,0,0, 1,0,8'h2A,1,1,0);
    for (int k = 1; k <= 3; k++) add("t1_open", 0,0,0,0,0, 1,0,8'h2A,1,1,0);
    add("t1_clear",   0,0,0,1,0, 0,0,8'h2A,1,1,0);
    add("t1_close",   0,0,0,1,0, 0,0,8'h2A,1,1,0);
    add("t1_close",   0,0,0,0,0, 0,0,8'h2A,1,1,0);
    add("t1_done",    0,0,0,0,0, 0,0,8'h2A,0,0,1);
    add("t1_idle",    0,0,0,0,0, 0,0,8'h2A,0,0,0);
    add("idle_ign",   0,0,0,1,1, 0,0,8'h2A,0,0,0);
    // 4: verdicts ignored outside IDLE, abort forces close, abort in CLOSE ignored
    add("t4_open",    1,0,8'h2A,0,0, 1,0,8'h2A,1,1,0);
    add("t4_ok_ign",  1,0,8'h55,0,0, 1,0,8'h2A,1,1,0);
    add("t4_pf_ign",  0,1,8'h55,0,0, 1,0,8'h2A,1,1,0);
    add("t4_abort",   0,0,0,0,1, 0,0,8'h2A,1,1,0);
    add("t4_close",   0,0,0,0,1, 0,0,8'h2A,1,1,0);
    add("t4_close",   0,0,0,0,0, 0,0,8'h2A,1,1,0);
    add("t4_done",    0,0,0,0,0, 0,0,8'h2A,0,0,1);
    // 2: no car_clear -> open exactly GATE_TMO cycles
    add("t2_open",    1,0,8'h77,0,0, 1,0,8'h77,1,1,0);
    for (int k = 1; k <= 9; k++) add("t2_open", 0,0,0,0,0, 1,0,8'h77,1,1,0);
    for (int k = 0; k < 3; k++)  add("t2_close", 0,0,0,0,0, 0,0,8'h77,1,1,0);
    add("t2_done",    0,0,0,0,0, 0,0,8'h77,0,0,1);
    // 3: both verdicts together -> alarm, fee not latched
    add("t3_alarm",   1,1,8'h99,0,0, 0,bz(0),8'h77,0,1,0);
    add("t3_alarm",   1,0,8'h99,0,0, 0,bz(1),8'h77,0,1,0);
    add("t3_alarm",   0,0,0,1,0, 0,bz(2),8'h77,0,1,0);
    add("t3_alarm",   0,0,0,0,0, 0,bz(3),8'h77,0,1,0);
    add("t3_done",    0,0,0,0,0, 0,0,8'h77,0,0,1);
    // 6: abort cuts the alarm short
    add("t6_alarm",   0,1,0,0,0, 0,bz(0),8'h77,0,1,0);
    add("t6_abort",   0,0,0,0,1, 0,0,8'h77,0,0,1);
    add("t6_idle",    0,0,0,0,0, 0,0,8'h77,0,0,0);
    run_vecs();

    // 5: asynchronous reset in the middle of OPEN
    drive('{po: 1'b1, pf: 1'b0, fee: 8'h3C, cc: 1'b0, ab: 1'b0});
    @(posedge clk);
    @(negedge clk);
    drive('0);
    chk("t5_open", '{go: 1'b1, bz: 1'b0, fd: 8'h3C, dv: 1'b1, bs: 1'b1, dn: 1'b0});
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("t5_async_rst", '0);
    @(negedge clk);
    chk("t5_held_rst", '0);
    rst = 1'b1;

    add("t5_idle",    0,0,0,0,0, 0,0,8'h00,0,0,0);
    add("t5_ok",      1,0,8'h3C,0,0, 1,0,8'h3C,1,1,0);
    add("t5_clear",   0,0,0,1,0, 0,0,8'h3C,1,1,0);
    add("t5_close",   0,0,0,0,0, 0,0,8'h3C,1,1,0);
    add("t5_close",   0,0,0,0,0, 0,0,8'h3C,1,1,0);
    add("t5_done",    0,0,0,0,0, 0,0,8'h3C,0,0,1);
    // reset mid-ALARM silences the buzzer without a clock edge
    add("t5_alarm",   0,1,0,0,0, 0,bz(0),8'h3C,0,1,0);
    run_vecs();
    #2 rst = 1'b0;
    #1 chk("t5_alarm_rst", '0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
